// File: rtl/spi_master_tx.sv
// SPI master transmit stage.
// Serialises bytes MSB-first on sclk/mosi with an active-low chip select.
// sclk idles high, the receiver samples on falling edges, and mosi changes
// on rising edges. Back-to-back bytes stream without releasing cs_n.
// All SPI-side outputs are registered. tx_ready is decoded from registers only.
module spi_master_tx #(
  parameter int HALF_PERIOD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic       busy,
  output logic       byte_done
);

  localparam int            DW       = $clog2(HALF_PERIOD + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF_PERIOD - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    LOW   = 2'd2,
    HIGH  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [DW-1:0] div_r, div_s;
  logic [2:0]    bit_r, bit_s;
  logic [7:0]    shift_r, shift_s;
  logic          last_r, last_s;

  logic sclk_r, sclk_s;
  logic mosi_r, mosi_s;
  logic cs_n_r, cs_n_s;
  logic busy_r, busy_s;
  logic byte_done_r, byte_done_s;

  logic phase_end_s;
  logic window_s;
  logic accept_s;

  // The final cycle of the 8th LOW phase doubles as the burst window.
  assign phase_end_s = (div_r == DIV_LAST);
  assign window_s    = (state_r == LOW) && (bit_r == 3'd7) && phase_end_s;
  assign tx_ready    = (state_r == IDLE) || window_s;
  assign accept_s    = tx_valid && tx_ready;

  assign sclk      = sclk_r;
  assign mosi      = mosi_r;
  assign cs_n      = cs_n_r;
  assign busy      = busy_r;
  assign byte_done = byte_done_r;

  // State register: FSM, counters, shifter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      div_r       <= '0;
      bit_r       <= 3'd0;
      shift_r     <= 8'd0;
      last_r      <= 1'b0;
      sclk_r      <= 1'b1;
      mosi_r      <= 1'b1;
      cs_n_r      <= 1'b1;
      busy_r      <= 1'b0;
      byte_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      div_r       <= div_s;
      bit_r       <= bit_s;
      shift_r     <= shift_s;
      last_r      <= last_s;
      sclk_r      <= sclk_s;
      mosi_r      <= mosi_s;
      cs_n_r      <= cs_n_s;
      busy_r      <= busy_s;
      byte_done_r <= byte_done_s;
    end
  end

  // Next-state logic: phase sequencing, byte loads and bit shifting.
  always_comb begin
    state_s = state_r;
    div_s   = div_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    last_s  = last_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = SETUP;
          div_s   = '0;
          shift_s = tx_data;
          bit_s   = 3'd0;
          last_s  = 1'b0;
        end else begin
          div_s = '0;
        end
      end
      SETUP: begin
        if (phase_end_s) begin
          state_s = LOW;
          div_s   = '0;
        end else begin
          div_s = div_r + DIV_ONE;
        end
      end
      LOW: begin
        if (phase_end_s) begin
          state_s = HIGH;
          div_s   = '0;
          if (bit_r == 3'd7) begin
            if (accept_s) begin
              // Burst: the coming HIGH phase acts as setup for the new byte.
              shift_s = tx_data;
              bit_s   = 3'd0;
              last_s  = 1'b0;
            end else begin
              // Ending: all-ones makes mosi return to its idle level.
              shift_s = 8'hFF;
              last_s  = 1'b1;
            end
          end else begin
            shift_s = {shift_r[6:0], 1'b0};
            bit_s   = bit_r + 3'd1;
          end
        end else begin
          div_s = div_r + DIV_ONE;
        end
      end
      HIGH: begin
        if (phase_end_s) begin
          div_s = '0;
          if (last_r) begin
            state_s = IDLE;
          end else begin
            state_s = LOW;
          end
        end else begin
          div_s = div_r + DIV_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        div_s   = '0;
        bit_s   = 3'd0;
        shift_s = 8'd0;
        last_s  = 1'b0;
      end
    endcase
  end

  // Output logic: next values of the registered SPI-side outputs.
  always_comb begin
    sclk_s      = (state_s != LOW);
    cs_n_s      = (state_s == IDLE);
    busy_s      = (state_s != IDLE);
    byte_done_s = (state_s == LOW) && (bit_s == 3'd7) && (div_s == DIV_LAST);
    if (state_s == IDLE) begin
      mosi_s = 1'b1;
    end else begin
      mosi_s = shift_s[7];
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: one instance with H=2, one with H=1,
// a shared receiver model that samples mosi on sclk falls.
`timescale 1ns/1ps
module tb_spi_master_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       sel = 1'b0;

  logic rdy0, sclk0, mosi0, csn0, busy0, bd0;
  logic rdy1, sclk1, mosi1, csn1, busy1, bd1;
  logic m_rdy, m_sclk, m_mosi, m_csn, m_busy, m_bd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int nfall, cs_low, bd_cnt, cs_rise, nacc, acc_cyc, ready_rise;
  int fall_cyc[64];
  int rx_cnt;
  logic [7:0] rx_sh;
  logic [7:0] rxq[$];
  logic prev_sclk, prev_rdy, prev_cs;

  spi_master_tx #(.HALF_PERIOD(2)) u_dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy0), .sclk(sclk0), .mosi(mosi0), .cs_n(csn0),
    .busy(busy0), .byte_done(bd0));

  spi_master_tx #(.HALF_PERIOD(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy1), .sclk(sclk1), .mosi(mosi1), .cs_n(csn1),
    .busy(busy1), .byte_done(bd1));

  assign m_rdy  = sel ? rdy1  : rdy0;
  assign m_sclk = sel ? sclk1 : sclk0;
  assign m_mosi = sel ? mosi1 : mosi0;
  assign m_csn  = sel ? csn1  : csn0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_bd   = sel ? bd1   : bd0;

  always #5 clk = ~clk;

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model and event statistics, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      rx_cnt    = 0;
      prev_sclk = 1'b1;
      prev_rdy  = 1'b1;
      prev_cs   = 1'b1;
    end else begin
      if (prev_sclk && !m_sclk && !m_csn) begin
        rx_sh = {rx_sh[6:0], m_mosi};
        if (nfall < 64) fall_cyc[nfall] = cyc;
        nfall++;
        rx_cnt++;
        if (rx_cnt == 8) begin
          rxq.push_back(rx_sh);
          rx_cnt = 0;
        end
      end
      if (!m_csn) cs_low++;
      if (m_bd) bd_cnt++;
      if (tx_valid && m_rdy) begin
        acc_cyc = cyc;
        nacc++;
      end
      if (!prev_rdy && m_rdy) ready_rise = cyc;
      if (!prev_cs && m_csn) cs_rise++;
      prev_sclk = m_sclk;
      prev_rdy  = m_rdy;
      prev_cs   = m_csn;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    nfall = 0; cs_low = 0; bd_cnt = 0; cs_rise = 0; nacc = 0;
    acc_cyc = 0; ready_rise = 0; rx_cnt = 0; rx_sh = 8'h00;
    rxq.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (m_busy && n < budget);
    check("idle_reached", int'(m_busy), 0);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic send_one(input logic [7:0] d);
    @(posedge clk); #1;
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  initial begin
    clear_stats();
    prev_sclk = 1'b1; prev_rdy = 1'b1; prev_cs = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_sclk", int'(sclk0), 1);
    check("rst_mosi", int'(mosi0), 1);
    check("rst_cs_n", int'(csn0), 1);
    check("rst_ready", int'(rdy0), 1);
    check("rst_busy", int'(busy0), 0);
    check("rst_byte_done", int'(bd0), 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Single byte 0x9F, H=2.
    clear_stats();
    send_one(8'h9F);
    wait_idle(100);
    check("single_rx_count", rxq.size(), 1);
    check("single_rx_byte", (rxq.size() > 0) ? int'(rxq[0]) : -1, 32'h9F);
    check("single_falls", nfall, 8);
    check("single_first_fall", fall_cyc[0] - acc_cyc, 3);
    check("single_fall_gap", fall_cyc[7] - fall_cyc[6], 4);
    check("single_cs_low", cs_low, 34);
    check("single_ready_back", ready_rise - acc_cyc, 35);
    check("single_byte_done", bd_cnt, 1);

    // Burst 0x9F then 0x9E with tx_valid held.
    clear_stats();
    @(posedge clk); #1;
    tx_data  = 8'h9F;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'h9E;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (nacc >= 2) break;
    end
    #1;
    tx_valid = 1'b0;
    wait_idle(100);
    check("burst_accepts", nacc, 2);
    check("burst_rx_count", rxq.size(), 2);
    check("burst_rx0", (rxq.size() > 0) ? int'(rxq[0]) : -1, 32'h9F);
    check("burst_rx1", (rxq.size() > 1) ? int'(rxq[1]) : -1, 32'h9E);
    check("burst_falls", nfall, 16);
    check("burst_gap_8_9", fall_cyc[8] - fall_cyc[7], 4);
    check("burst_cs_rises", cs_rise, 1);
    check("burst_cs_low", cs_low, 66);
    check("burst_byte_done", bd_cnt, 2);

    // tx_valid raised mid-byte and dropped before the burst window.
    clear_stats();
    send_one(8'h3C);
    repeat (10) @(posedge clk);
    #1;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tx_valid = 1'b0;
    wait_idle(100);
    repeat (40) @(posedge clk);
    #1;
    check("ignore_accepts", nacc, 1);
    check("ignore_rx_count", rxq.size(), 1);
    check("ignore_rx_byte", (rxq.size() > 0) ? int'(rxq[0]) : -1, 32'h3C);
    check("ignore_falls", nfall, 8);
    check("ignore_cs_rises", cs_rise, 1);

    // Reset pulse after the 3rd fall of 0xFF.
    clear_stats();
    send_one(8'hFF);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (nfall >= 3) break;
    end
    check("abort_third_fall", nfall, 3);
    rst = 1'b0;
    #1;
    check("abort_sclk", int'(sclk0), 1);
    check("abort_mosi", int'(mosi0), 1);
    check("abort_cs_n", int'(csn0), 1);
    check("abort_busy", int'(busy0), 0);
    check("abort_ready", int'(rdy0), 1);
    check("abort_byte_done", int'(bd0), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    check("abort_no_done", bd_cnt, 0);
    clear_stats();
    send_one(8'h55);
    wait_idle(100);
    check("after_abort_rx_count", rxq.size(), 1);
    check("after_abort_rx_byte", (rxq.size() > 0) ? int'(rxq[0]) : -1, 32'h55);

    // HALF_PERIOD=1, 0xA5.
    repeat (5) @(posedge clk);
    #1;
    sel = 1'b1;
    repeat (2) @(posedge clk);
    clear_stats();
    send_one(8'hA5);
    wait_idle(100);
    check("h1_rx_count", rxq.size(), 1);
    check("h1_rx_byte", (rxq.size() > 0) ? int'(rxq[0]) : -1, 32'hA5);
    check("h1_first_fall", fall_cyc[0] - acc_cyc, 2);
    check("h1_fall_gap", fall_cyc[1] - fall_cyc[0], 2);
    check("h1_cs_low", cs_low, 17);
    check("h1_ready_back", ready_rise - acc_cyc, 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
